psone_pad_slave: RTL
====================

# psone_pad_slave

Controller-side (responder) end of the PlayStation pad serial link: emulates a digital pad (optionally analog) toward a PSX-style host. Synchronizes the host's ATT/CLK/CMD lines into iCLK, decodes the poll command, shifts back ID, status and button bytes LSB-first, and generates the per-byte ACK pulse. Sits behind the board pins, fed with button state from the keypad/debounce logic.

## Interface
- ACK_DELAY, 40 — iCLK cycles from the detected 8th rising SCK edge of a byte to ACK assertion
- ACK_WIDTH, 20 — iCLK cycles oACK is held low
- iCLK  in  1  system clock
- iRESET  in  1  asynchronous, active-high reset
- iATT  in  1  host attention, active low (packet frame)
- iSCK  in  1  host serial clock, idle high
- iCMD  in  1  host command data
- oDAT  out  1  response data (to open-drain/tri-state pad)
- oDAT_OE  out  1  1 = drive oDAT onto the line
- oACK  out  1  acknowledge, active low
- iBUTTONS  in  16  button state, active low (bit 0 = SELECT … bit 15 = SQUARE)
- iANALOG  in  32  {LY, LX, RY, RX} sticks, present only with PSONE_PAD_ANALOG_EN
- oPOLL  out  1  one-cycle pulse when a complete valid poll packet ends
- oBUSY  out  1  high while a packet is in progress (ATT low, not ignoring)

## Operation
- iATT, iSCK, iCMD each pass a 2-flop synchronizer; edges detected on synchronized values.
- States: IDLE, ADDR, CMD, DATA, IGNORE.
- IDLE: falling ATT -> ADDR; bit counter and byte index cleared; iBUTTONS (and iANALOG) latched into response register.
- Bit rules: response bit presented on each detected falling SCK; iCMD sampled on each detected rising SCK; LSB first; byte complete on 8th rising edge.
- ADDR (byte 0): oDAT_OE=0. Received 0x01 -> ACK sequence, -> CMD; else -> IGNORE, no ACK.
- CMD (byte 1): reply ID (0x41, or 0x73 with analog). Received 0x42 -> ACK, -> DATA; else -> IGNORE, no ACK.
- DATA: bytes 2..N-1 reply 0x5A, BTN[7:0], BTN[15:8], then analog bytes RX, RY, LX, LY if enabled; received bytes ignored. ACK after every byte except the last. After the last byte: oPOLL pulse, -> IGNORE.
- IGNORE: oDAT_OE=0, oACK=1, no response until ATT rises -> IDLE.
- Rising ATT in any state: abort, oDAT_OE=0, oACK=1 on next cycle, -> IDLE; oPOLL only if last byte already completed.
- ACK sequence: counter runs ACK_DELAY cycles, then oACK=0 for ACK_WIDTH cycles. A falling SCK during delay or pulse terminates it (oACK=1 next cycle).
- Reset release with ATT low: enter IGNORE, not ADDR; a packet is never joined mid-frame.

## Timing
- Reset values: oDAT=1, oDAT_OE=0, oACK=1, oPOLL=0, oBUSY=0; state IDLE.
- Pin edge -> internal edge event: 3 iCLK cycles. Pin falling SCK -> new oDAT value: 4 cycles.
- Host SCK half-period must be ≥ 8 iCLK cycles; below that, behaviour undefined.
- oDAT_OE rises with the first falling SCK of byte 1; falls 1 cycle after ATT-rise detection.
- oPOLL: one cycle, 1 cycle after the final byte's 8th rising edge is detected.
- ACK counter 8 bits; ACK_DELAY, ACK_WIDTH in 1..255.

## Configuration
- PSONE_PAD_ANALOG_EN defined: iANALOG port present, ID 0x73, 9-byte packet, ACK after bytes 0-7.
- Undefined: no iANALOG, ID 0x41, 5-byte packet, ACK after bytes 0-3.

## Structure
- Package psone_pad_pkg: state enum; constants ADDR_PAD=8'h01, CMD_POLL=8'h42, ID_DIGITAL=8'h41, ID_ANALOG=8'h73, RESP_READY=8'h5A; packet-length constants per configuration.
- Sub-module psone_sync_edge (2-flop sync + rise/fall pulses), instantiated for ATT, SCK, CMD.

## Test plan
- Digital poll, host sends 01 42 00 00 00, iBUTTONS=16'hFFFE -> reply bytes (hi-Z) 41 5A FE FF; 4 ACK pulses of ACK_WIDTH; oPOLL once.
- Address 0x81 -> oDAT_OE stays 0, no ACK, no oPOLL until ATT cycles; next valid packet answered normally.
- Command 0x43 after 0x01 -> ID 0x41 shifted, no ACK after byte 1, IGNORE until ATT high.
- ATT raised after byte 2 -> oACK=1, oDAT_OE=0 within 4 cycles of pin edge, no oPOLL.
- iBUTTONS changed from FFFF to 0000 mid-packet -> reply still FF FF (latched at ATT fall).
- With PSONE_PAD_ANALOG_EN, iANALOG=32'h80_7F_10_F0 -> reply 73 5A BTNlo BTNhi F0 10 7F 80, 8 ACKs, oPOLL.

Source files
------------

// File: rtl/psone_pad_pkg.sv
// Shared types and protocol constants for the PlayStation pad responder.
// PSONE_PAD_ANALOG_EN selects the analog pad ID and the 9-byte packet.
package psone_pad_pkg;

   typedef enum logic [2:0] {StIdle, StAddr, StCmd, StData, StIgnore} pad_state_e;
   typedef enum logic [1:0] {AckOff, AckDelay, AckLow} ack_phase_e;

   localparam logic [7:0] ADDR_PAD   = 8'h01;
   localparam logic [7:0] CMD_POLL   = 8'h42;
   localparam logic [7:0] ID_DIGITAL = 8'h41;
   localparam logic [7:0] ID_ANALOG  = 8'h73;
   localparam logic [7:0] RESP_READY = 8'h5A;

   localparam int unsigned PKT_LEN_DIGITAL = 5;
   localparam int unsigned PKT_LEN_ANALOG  = 9;

`ifdef PSONE_PAD_ANALOG_EN
   localparam logic [7:0]  PAD_ID  = ID_ANALOG;
   localparam int unsigned PKT_LEN = PKT_LEN_ANALOG;
`else
   localparam logic [7:0]  PAD_ID  = ID_DIGITAL;
   localparam int unsigned PKT_LEN = PKT_LEN_DIGITAL;
`endif

   localparam logic [3:0] LAST_BYTE = 4'(PKT_LEN - 1);

endpackage

// File: rtl/psone_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; level is aligned
// with the pulses so both can be used together in the same cycle.
module psone_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q, rise_q, fall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/psone_pad_slave.sv
// PlayStation pad responder: decodes the poll packet and shifts back ID,
// status and buttons LSB-first. PSONE_PAD_ANALOG_EN adds the stick bytes.
module psone_pad_slave
   import psone_pad_pkg::*;
#(
   parameter int unsigned ACK_DELAY = 40,
   parameter int unsigned ACK_WIDTH = 20
) (
   input  logic        iCLK,
   input  logic        iRESET,
   input  logic        iATT,
   input  logic        iSCK,
   input  logic        iCMD,
   output logic        oDAT,
   output logic        oDAT_OE,
   output logic        oACK,
   input  logic [15:0] iBUTTONS,
`ifdef PSONE_PAD_ANALOG_EN
   input  logic [31:0] iANALOG,
`endif
   output logic        oPOLL,
   output logic        oBUSY
);

   logic att_lvl, att_rise, att_fall;
   logic sck_rise, sck_fall;
   logic cmd_lvl;

   psone_sync_edge #(.RST_VAL(1'b1)) u_sync_att (
      .clk(iCLK), .rst(iRESET), .din(iATT),
      .level(att_lvl), .rise(att_rise), .fall(att_fall)
   );

   psone_sync_edge #(.RST_VAL(1'b1)) u_sync_sck (
      .clk(iCLK), .rst(iRESET), .din(iSCK),
      .level(), .rise(sck_rise), .fall(sck_fall)
   );

   psone_sync_edge #(.RST_VAL(1'b1)) u_sync_cmd (
      .clk(iCLK), .rst(iRESET), .din(iCMD),
      .level(cmd_lvl), .rise(), .fall()
   );

   pad_state_e state_q;
   ack_phase_e ack_ph_q;
   logic [7:0]  ack_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [3:0]  byte_idx_q;
   logic [7:0]  rx_q;
   logic [15:0] btn_q;
`ifdef PSONE_PAD_ANALOG_EN
   logic [31:0] ana_q;
`endif
   logic [2:0]  settle_q;
   logic        dat_q, oe_q, ack_q, poll_q;

   logic [7:0] tx_byte;
   logic [7:0] rx_byte;
   logic       byte_done;
   logic       settled;

   assign rx_byte   = {cmd_lvl, rx_q[7:1]};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
   // Synchronizer reset values must flush out before a level can be trusted.
   assign settled   = (settle_q == 3'd4);

   always_comb begin
      tx_byte = 8'hFF;
      case (byte_idx_q)
         4'd1:    tx_byte = PAD_ID;
         4'd2:    tx_byte = RESP_READY;
         4'd3:    tx_byte = btn_q[7:0];
         4'd4:    tx_byte = btn_q[15:8];
`ifdef PSONE_PAD_ANALOG_EN
         4'd5:    tx_byte = ana_q[7:0];
         4'd6:    tx_byte = ana_q[15:8];
         4'd7:    tx_byte = ana_q[23:16];
         4'd8:    tx_byte = ana_q[31:24];
`endif
         default: tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q    <= StIdle;
         ack_ph_q   <= AckOff;
         ack_cnt_q  <= 8'd0;
         bit_cnt_q  <= 3'd0;
         byte_idx_q <= 4'd0;
         rx_q       <= 8'd0;
         btn_q      <= 16'hFFFF;
`ifdef PSONE_PAD_ANALOG_EN
         ana_q      <= 32'd0;
`endif
         settle_q   <= 3'd0;
         dat_q      <= 1'b1;
         oe_q       <= 1'b0;
         ack_q      <= 1'b1;
         poll_q     <= 1'b0;
      end else begin
         poll_q <= 1'b0;
         if (!settled) settle_q <= settle_q + 3'd1;

         case (ack_ph_q)
            AckDelay: begin
               if (ack_cnt_q == 8'd0) begin
                  ack_q     <= 1'b0;
                  ack_cnt_q <= 8'(ACK_WIDTH - 1);
                  ack_ph_q  <= AckLow;
               end else begin
                  ack_cnt_q <= ack_cnt_q - 8'd1;
               end
            end
            AckLow: begin
               if (ack_cnt_q == 8'd0) begin
                  ack_q    <= 1'b1;
                  ack_ph_q <= AckOff;
               end else begin
                  ack_cnt_q <= ack_cnt_q - 8'd1;
               end
            end
            default: ;
         endcase
         // Host clocking the next byte cuts any pending or active ACK short.
         if (sck_fall) begin
            ack_q    <= 1'b1;
            ack_ph_q <= AckOff;
         end

         if (att_rise && state_q != StIdle) begin
            state_q  <= StIdle;
            oe_q     <= 1'b0;
            dat_q    <= 1'b1;
            ack_q    <= 1'b1;
            ack_ph_q <= AckOff;
         end else begin
            case (state_q)
               StIdle: begin
                  if (settled) begin
                     if (att_fall) begin
                        state_q    <= StAddr;
                        bit_cnt_q  <= 3'd0;
                        byte_idx_q <= 4'd0;
                        btn_q      <= iBUTTONS;
`ifdef PSONE_PAD_ANALOG_EN
                        ana_q      <= iANALOG;
`endif
                     end else if (!att_lvl) begin
                        state_q <= StIgnore;
                     end
                  end
               end
               StAddr, StCmd, StData: begin
                  if (sck_fall && state_q != StAddr) begin
                     oe_q  <= 1'b1;
                     dat_q <= tx_byte[bit_cnt_q];
                  end
                  if (sck_rise) begin
                     rx_q      <= rx_byte;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
                  if (byte_done) begin
                     byte_idx_q <= byte_idx_q + 4'd1;
                     if ((state_q == StAddr && rx_byte == ADDR_PAD) ||
                         (state_q == StCmd && rx_byte == CMD_POLL) ||
                         (state_q == StData && byte_idx_q != LAST_BYTE)) begin
                        ack_ph_q  <= AckDelay;
                        ack_cnt_q <= 8'(ACK_DELAY - 1);
                        if (state_q == StAddr) state_q <= StCmd;
                        if (state_q == StCmd)  state_q <= StData;
                     end else begin
                        if (state_q == StData) poll_q <= 1'b1;
                        state_q  <= StIgnore;
                        oe_q     <= 1'b0;
                        dat_q    <= 1'b1;
                        ack_q    <= 1'b1;
                        ack_ph_q <= AckOff;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign oDAT    = dat_q;
   assign oDAT_OE = oe_q;
   assign oACK    = ack_q;
   assign oPOLL   = poll_q;
   assign oBUSY   = (state_q == StAddr) || (state_q == StCmd) || (state_q == StData);

endmodule
